// File: rtl/square_root.sv
// Sequential integer square root by odd-number accumulation.
// One comparison per clock; reset release starts a computation.
module square_root #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   valor_i,
  output logic               ready_o,
  output logic [WIDTH/2-1:0] root_o
);

  localparam int RW = WIDTH / 2;
  localparam int DW = RW + 2;
  localparam int SW = WIDTH + 1;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   square;
  logic [DW-1:0]   delta;
  logic [WIDTH-1:0] operand;
  logic            fits;

  assign fits = square <= {1'b0, operand};

  // rst_n is active-high here despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= LOAD;
      root_o  <= '0;
      ready_o <= 1'b1;
      square  <= SW'(1);
      delta   <= DW'(3);
      operand <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          operand <= valor_i;
          state   <= CALC;
        end
        CALC: begin
          if (fits) begin
            square <= square + SW'(delta);
            delta  <= delta + DW'(2);
            root_o <= root_o + 1'b1;
          end else begin
            state   <= DONE;
            ready_o <= 1'b0;
          end
        end
        DONE: begin
          ready_o <= 1'b0;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_root.sv
// Scoreboard bench for square_root: expected roots queued at reset
// release, popped and compared when ready_o falls.
module tb_square_root;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W-1:0]   valor_i = '0;
  logic           ready_o;
  logic [W/2-1:0] root_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  square_root #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valor_i (valor_i),
    .ready_o (ready_o),
    .root_o  (root_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic run(input int v, input bit hold);
    int n;
    int e;
    rst_n   = 1'b1;
    valor_i = v[W-1:0];
    @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 1);
    check("rst_root", 32'(root_o), 0);
    rst_n = 1'b0;
    exp_q.push_back(isqrt(v));
    n = 0;
    while (ready_o === 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    check($sformatf("done_%0d", v), 32'(ready_o), 0);
    check($sformatf("lat_%0d", v), n, e + 2);
    check($sformatf("root_%0d", v), 32'(root_o), e);
    if (hold) begin
      valor_i = ~valor_i;
      repeat (10) @(posedge clk);
      #1;
      check("hold_root", 32'(root_o), e);
      check("hold_ready", 32'(ready_o), 0);
    end
  endtask

  initial begin
    // reset held: outputs pinned regardless of operand and clock
    for (int k = 0; k < 4; k++) begin
      valor_i = W'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("held_ready", 32'(ready_o), 1);
      check("held_root", 32'(root_o), 0);
    end

    run(0, 1'b1);
    run(1, 1'b0);
    run(2, 1'b0);
    run(3, 1'b0);
    run(4, 1'b1);
    run(255, 1'b0);
    run(256, 1'b1);
    run(65535, 1'b1);

    // abort mid-calculation, then restart with a new operand
    rst_n   = 1'b1;
    valor_i = 16'd10000;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("mid_root", 32'(root_o), 49);
    check("mid_ready", 32'(ready_o), 1);
    #2;
    rst_n = 1'b1;
    #1;
    check("abort_ready", 32'(ready_o), 1);
    check("abort_root", 32'(root_o), 0);
    run(144, 1'b1);

    // squares and their predecessors across the range
    for (int i = 1; i < 256; i += 3) begin
      run(i * i - 1, 1'b0);
      run(i * i, (i % 48) == 1);
    end

    for (int k = 0; k < 20; k++) begin
      run(int'($urandom_range(65535, 0)), 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
